writeback_unit: RTL and testbench

Write-back stage that sits directly upstream of the register file's write port and drives its `regWrite`, `writeRegister` and `writeData` inputs. It merges two result sources. The single-cycle ALU path has fixed priority. The variable-latency memory/long-op path has a valid/ready handshake and is buffered in a small FIFO. Writes to register 0 are dropped here, so register 0 stays constant without any help from the register file. Queued writes that an ALU write makes stale are cancelled.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/writeback_unit.sv | 80 ++++++++
 tb/tb_writeback_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared write-back definitions: datapath widths and the long-path queue entry.
package wb_pkg;

    localparam int WordLen    = 32;
    localparam int RegAddrLen = 5;

    // One queued long-path result; kill marks an entry made stale by a later ALU write.
    typedef struct packed {
        logic [RegAddrLen-1:0] regIdx;
        logic [WordLen-1:0]    data;
        logic                  kill;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for long-path write-back results with per-entry cancellation by register index.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int FifoDepth = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pushEn,
    input  wb_entry_t                     pushEntry,
    input  logic                          popEn,
    input  logic                          killEn,
    input  logic [RegAddrLen-1:0]         killReg,
    output wb_entry_t                     head,
    output logic [$clog2(FifoDepth):0]    count,
    output logic                          full,
    output logic                          empty
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);

    wb_entry_t          mem [FifoDepth];
    logic [PtrW-1:0]    wrPtr;
    logic [PtrW-1:0]    rdPtr;

    assign head  = mem[rdPtr];
    assign full  = (count == FullCount);
    assign empty = (count == '0);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + 1'b1;
            if (popEn)  rdPtr <= rdPtr + 1'b1;
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage: cancel stale entries first, then let a push overwrite its slot with a fresh entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FifoDepth; i++) mem[i].kill <= 1'b0;
        end else begin
            for (int i = 0; i < FifoDepth; i++) begin
                if (killEn && (mem[i].regIdx == killReg)) mem[i].kill <= 1'b1;
            end
            if (pushEn) mem[wrPtr] <= pushEntry;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back arbiter: ALU results take priority, long-path results queue and drain when the ALU is idle.
module writeback_unit #(
    parameter int WordLen    = wb_pkg::WordLen,
    parameter int RegAddrLen = wb_pkg::RegAddrLen,
    parameter int FifoDepth  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          aluWbValid,
    input  logic [RegAddrLen-1:0]         aluWbReg,
    input  logic [WordLen-1:0]            aluWbData,
    input  logic                          memWbValid,
    output logic                          memWbReady,
    input  logic [RegAddrLen-1:0]         memWbReg,
    input  logic [WordLen-1:0]            memWbData,
    output logic                          regWrite,
    output logic [RegAddrLen-1:0]         writeRegister,
    output logic [WordLen-1:0]            writeData,
    output logic [$clog2(FifoDepth):0]    fifoCount,
    output logic                          busy
);

    import wb_pkg::*;

    logic      aluActive;
    logic      memAccept;
    logic      pushEn;
    logic      popEn;
    logic      fifoFull;
    logic      fifoEmpty;
    wb_entry_t pushEntry;
    wb_entry_t headEntry;

    // An ALU write to r0 is treated as no ALU activity at all.
    assign aluActive  = aluWbValid && (aluWbReg != '0);
    // Ready comes from registered occupancy only, so a same-cycle pop never opens a slot early.
    assign memWbReady = !rst && !fifoFull;
    assign memAccept  = memWbValid && memWbReady;
    // Accepted r0 writes and writes shadowed by a same-cycle ALU write to the same register are dropped.
    assign pushEn     = memAccept && (memWbReg != '0) && !(aluWbValid && (aluWbReg == memWbReg));
    assign popEn      = !aluActive && !fifoEmpty;
    assign pushEntry  = '{regIdx: memWbReg, data: memWbData, kill: 1'b0};
    assign busy       = (fifoCount != '0);

    wb_fifo #(
        .FifoDepth (FifoDepth)
    ) uFifo (
        .clk       (clk),
        .rst       (rst),
        .pushEn    (pushEn),
        .pushEntry (pushEntry),
        .popEn     (popEn),
        .killEn    (aluActive),
        .killReg   (aluWbReg),
        .head      (headEntry),
        .count     (fifoCount),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    // Register-file write port: ALU first, then the queue head (killed heads drain silently).
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else if (aluActive) begin
            regWrite      <= 1'b1;
            writeRegister <= aluWbReg;
            writeData     <= aluWbData;
        end else if (popEn) begin
            regWrite      <= !headEntry.kill;
            writeRegister <= headEntry.regIdx;
            writeData     <= headEntry.data;
        end else begin
            regWrite      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table plus randomized traffic against a queue model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluWbValid;
    logic [4:0]  aluWbReg;
    logic [31:0] aluWbData;
    logic        memWbValid;
    logic        memWbReady;
    logic [4:0]  memWbReg;
    logic [31:0] memWbData;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [2:0]  fifoCount;
    logic        busy;

    int checks = 0;
    int errors = 0;

    writeback_unit dut (
        .clk           (clk),
        .rst           (rst),
        .aluWbValid    (aluWbValid),
        .aluWbReg      (aluWbReg),
        .aluWbData     (aluWbData),
        .memWbValid    (memWbValid),
        .memWbReady    (memWbReady),
        .memWbReg      (memWbReg),
        .memWbData     (memWbData),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .fifoCount     (fifoCount),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        eRdy;
        logic        eRw;
        logic [4:0]  eReg;
        logic [31:0] eData;
        int          eCnt;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          k;
    } ment_t;

    vec_t  vecs[$];
    ment_t mq[$];
    bit          mRw;
    logic [4:0]  mReg;
    logic [31:0] mData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue advanced by the write-back rules for one clock edge.
    task automatic modelStep(input vec_t v);
        bit    rdy;
        bit    aluAct;
        ment_t e;
        rdy = !v.r && (mq.size() < 4);
        if (v.r) begin
            mq.delete();
            mRw = 1'b0;
            mReg = '0;
            mData = '0;
        end else begin
            aluAct = v.av && (v.ar != 0);
            if (aluAct) begin
                foreach (mq[i]) if (mq[i].r == v.ar) mq[i].k = 1'b1;
                mRw = 1'b1;
                mReg = v.ar;
                mData = v.ad;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                mRw = !e.k;
                mReg = e.r;
                mData = e.d;
            end else begin
                mRw = 1'b0;
            end
            if (v.mv && rdy && (v.mr != 0) && !(v.av && (v.ar == v.mr)))
                mq.push_back('{v.mr, v.md, 1'b0});
        end
    endtask

    // Drive one cycle, check ready before the edge and outputs just after it.
    task automatic runCycle(input vec_t v, input bit useTable, input int idx);
        string tag;
        tag = useTable ? $sformatf("vec%0d", idx) : $sformatf("rnd%0d", idx);
        rst        = v.r;
        aluWbValid = v.av;
        aluWbReg   = v.ar;
        aluWbData  = v.ad;
        memWbValid = v.mv;
        memWbReg   = v.mr;
        memWbData  = v.md;
        #1;
        chk({tag, " model ready"}, 32'(memWbReady), 32'(!v.r && (mq.size() < 4)));
        if (useTable) chk({tag, " ready"}, 32'(memWbReady), 32'(v.eRdy));
        @(posedge clk);
        modelStep(v);
        #1;
        chk({tag, " model regWrite"}, 32'(regWrite), 32'(mRw));
        if (mRw) begin
            chk({tag, " model writeRegister"}, 32'(writeRegister), 32'(mReg));
            chk({tag, " model writeData"}, writeData, mData);
        end
        chk({tag, " model fifoCount"}, 32'(fifoCount), 32'(mq.size()));
        chk({tag, " model busy"}, 32'(busy), 32'(mq.size() != 0));
        if (useTable) begin
            chk({tag, " regWrite"}, 32'(regWrite), 32'(v.eRw));
            if (v.eRw || v.r) begin
                chk({tag, " writeRegister"}, 32'(writeRegister), 32'(v.eReg));
                chk({tag, " writeData"}, writeData, v.eData);
            end
            chk({tag, " fifoCount"}, 32'(fifoCount), 32'(v.eCnt));
        end
    endtask

    initial begin
        vec_t v;
        //              r  av ar  ad        mv mr  md      eRdy eRw eReg eData     eCnt
        vecs.push_back('{1, 0, 0,  0,        0, 0,  0,      0,   0,  0,   0,        0});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   0,  0,   0,        0});
        vecs.push_back('{0, 1, 5,  'h1234,   0, 0,  0,      1,   1,  5,   'h1234,   0});
        vecs.push_back('{0, 1, 0,  'hFFFF,   0, 0,  0,      1,   0,  0,   0,        0});
        vecs.push_back('{0, 0, 0,  0,        1, 7,  'hA,    1,   0,  0,   0,        1});
        vecs.push_back('{0, 0, 0,  0,        1, 8,  'hB,    1,   1,  7,   'hA,      1});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   1,  8,   'hB,      0});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   0,  0,   0,        0});
        vecs.push_back('{0, 1, 1,  'h100,    1, 10, 'h10,   1,   1,  1,   'h100,    1});
        vecs.push_back('{0, 1, 1,  'h101,    1, 11, 'h11,   1,   1,  1,   'h101,    2});
        vecs.push_back('{0, 1, 1,  'h102,    1, 12, 'h12,   1,   1,  1,   'h102,    3});
        vecs.push_back('{0, 1, 1,  'h103,    1, 13, 'h13,   1,   1,  1,   'h103,    4});
        vecs.push_back('{0, 1, 1,  'h104,    1, 14, 'h14,   0,   1,  1,   'h104,    4});
        vecs.push_back('{0, 0, 0,  0,        1, 14, 'h14,   0,   1,  10,  'h10,     3});
        vecs.push_back('{0, 0, 0,  0,        1, 14, 'h14,   1,   1,  11,  'h11,     3});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   1,  12,  'h12,     2});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   1,  13,  'h13,     1});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   1,  14,  'h14,     0});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   0,  0,   0,        0});
        vecs.push_back('{0, 0, 0,  0,        1, 9,  'h1,    1,   0,  0,   0,        1});
        vecs.push_back('{0, 1, 9,  'h2,      0, 0,  0,      1,   1,  9,   'h2,      1});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   0,  0,   0,        0});
        vecs.push_back('{0, 1, 9,  'h3,      1, 9,  'h4,    1,   1,  9,   'h3,      0});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   0,  0,   0,        0});
        vecs.push_back('{0, 0, 0,  0,        1, 0,  'h5,    1,   0,  0,   0,        0});
        vecs.push_back('{0, 1, 2,  'h20,     1, 3,  'h30,   1,   1,  2,   'h20,     1});
        vecs.push_back('{0, 1, 2,  'h21,     1, 4,  'h40,   1,   1,  2,   'h21,     2});
        vecs.push_back('{0, 1, 2,  'h22,     1, 6,  'h60,   1,   1,  2,   'h22,     3});
        vecs.push_back('{1, 0, 0,  0,        0, 0,  0,      0,   0,  0,   0,        0});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   0,  0,   0,        0});
        vecs.push_back('{0, 0, 0,  0,        0, 0,  0,      1,   0,  0,   0,        0});

        rst = 1'b1;
        aluWbValid = 1'b0; aluWbReg = '0; aluWbData = '0;
        memWbValid = 1'b0; memWbReg = '0; memWbData = '0;
        mRw = 1'b0; mReg = '0; mData = '0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) runCycle(vecs[i], 1'b1, i);

        for (int n = 0; n < 600; n++) begin
            v = '{default: '0};
            v.r  = ($urandom_range(0, 79) == 0);
            v.av = ($urandom_range(0, 99) < 40);
            v.ar = 5'($urandom_range(0, 6));
            v.ad = $urandom;
            v.mv = ($urandom_range(0, 99) < 60);
            v.mr = 5'($urandom_range(0, 6));
            v.md = $urandom;
            runCycle(v, 1'b0, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
